// File: rtl/reg32_reader.sv
// rtl/reg32_reader.sv - snapshot a 32-bit register and stream it out one byte lane at a time
// Optional build macro REG32_READER_MSB_FIRST_EN reverses lane order (lane 3 first).
module reg32_reader #(
    parameter int unsigned STALL_MAX = 255
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        start,
    input  logic [31:0] rd_data,
    output logic [7:0]  byte_out,
    output logic [1:0]  byte_sel,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        DONE  = 2'd2,
        ABORT = 2'd3
    } state_t;

`ifdef REG32_READER_MSB_FIRST_EN
    localparam logic [1:0] FIRST_LANE = 2'd3;
    localparam logic [1:0] LAST_LANE  = 2'd0;
`else
    localparam logic [1:0] FIRST_LANE = 2'd0;
    localparam logic [1:0] LAST_LANE  = 2'd3;
`endif

    localparam logic [7:0] STALL_LIMIT = 8'(STALL_MAX);

    state_t      state_q, state_d;
    logic [31:0] shadow_q, shadow_d;
    logic [1:0]  idx_q, idx_d;
    logic [7:0]  stall_q, stall_d;
    logic [1:0]  idx_next;
    logic [7:0]  lane_byte;

`ifdef REG32_READER_MSB_FIRST_EN
    assign idx_next = idx_q - 2'd1;
`else
    assign idx_next = idx_q + 2'd1;
`endif

    always_ff @(posedge clock or posedge resetn) begin
        if (resetn) begin
            state_q  <= IDLE;
            shadow_q <= 32'd0;
            idx_q    <= 2'd0;
            stall_q  <= 8'd0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            idx_q    <= idx_d;
            stall_q  <= stall_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        idx_d    = idx_q;
        stall_d  = stall_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    shadow_d = rd_data;
                    idx_d    = FIRST_LANE;
                    stall_d  = 8'd0;
                    state_d  = SEND;
                end
            end
            SEND: begin
                if (byte_ready) begin
                    stall_d = 8'd0;
                    if (idx_q == LAST_LANE) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_next;
                    end
                // Abort only once the counter already sits at the limit, so
                // exactly STALL_MAX stalled edges are still tolerated.
                end else if (stall_q == STALL_LIMIT) begin
                    state_d = ABORT;
                end else begin
                    stall_d = stall_q + 8'd1;
                end
            end
            DONE:    state_d = IDLE;
            ABORT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        lane_byte = 8'd0;
        case (idx_q)
            2'd0: lane_byte = shadow_q[7:0];
            2'd1: lane_byte = shadow_q[15:8];
            2'd2: lane_byte = shadow_q[23:16];
            2'd3: lane_byte = shadow_q[31:24];
            default: lane_byte = 8'd0;
        endcase
    end

    assign byte_valid = (state_q == SEND);
    assign byte_out   = byte_valid ? lane_byte : 8'd0;
    assign byte_sel   = byte_valid ? idx_q : 2'd0;
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign err        = (state_q == ABORT);

endmodule

// File: tb/tb_reg32_reader.sv
// tb/tb_reg32_reader.sv - directed self-checking bench for reg32_reader (STALL_MAX=3)
module tb_reg32_reader;

    logic        clock = 1'b0;
    logic        resetn;
    logic        start;
    logic [31:0] rd_data;
    logic [7:0]  byte_out;
    logic [1:0]  byte_sel;
    logic        byte_valid;
    logic        byte_ready;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

    // {byte_valid, byte_sel, byte_out, busy, done, err}
    logic [13:0] obs;
    logic [13:0] exp_v;
    assign obs = {byte_valid, byte_sel, byte_out, busy, done, err};

    reg32_reader #(.STALL_MAX(3)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .start      (start),
        .rd_data    (rd_data),
        .byte_out   (byte_out),
        .byte_sel   (byte_sel),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clock = ~clock;

    function automatic logic [1:0] lane_of(input int k);
`ifdef REG32_READER_MSB_FIRST_EN
        return 2'(3 - k);
`else
        return 2'(k);
`endif
    endfunction

    function automatic logic [7:0] byte_of(input logic [31:0] w, input int k);
        logic [1:0] l;
        l = lane_of(k);
        return w[l*8 +: 8];
    endfunction

    function automatic logic [13:0] send_vec(input logic [31:0] w, input int k);
        return {1'b1, lane_of(k), byte_of(w, k), 1'b1, 1'b0, 1'b0};
    endfunction

    localparam logic [13:0] IDLE_V  = 14'b0_00_00000000_000;
    localparam logic [13:0] DONE_V  = 14'b0_00_00000000_110;
    localparam logic [13:0] ABORT_V = 14'b0_00_00000000_101;

    task automatic test_reset();
        resetn = 1'b1; start = 1'b0; rd_data = 32'hFFFF_FFFF; byte_ready = 1'b1;
        repeat (2) @(negedge clock);
        checks++;
        if (obs !== IDLE_V) begin
            errors++; $display("FAIL reset_outputs: got %h expected %h", obs, IDLE_V);
        end
        resetn = 1'b0;
        @(negedge clock);
        checks++;
        if (obs !== IDLE_V) begin
            errors++; $display("FAIL idle_after_release: got %h expected %h", obs, IDLE_V);
        end
    endtask

    task automatic test_basic();
        @(negedge clock);
        rd_data = 32'hA1B2_C3D4; start = 1'b1; byte_ready = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            exp_v = send_vec(32'hA1B2_C3D4, k);
            checks++;
            if (obs !== exp_v) begin
                errors++; $display("FAIL basic_byte%0d: got %h expected %h", k, obs, exp_v);
            end
            @(negedge clock);
        end
        checks++;
        if (obs !== DONE_V) begin
            errors++; $display("FAIL basic_done: got %h expected %h", obs, DONE_V);
        end
        @(negedge clock);
        checks++;
        if (obs !== IDLE_V) begin
            errors++; $display("FAIL basic_idle_after: got %h expected %h", obs, IDLE_V);
        end
    endtask

    task automatic test_hold_stable();
        int k;
        int cyc;
        k = 0;
        cyc = 0;
        rd_data = 32'hA1B2_C3D4; start = 1'b1; byte_ready = 1'b1;
        @(negedge clock);
        start = 1'b0; rd_data = 32'h0;
        while (k < 4 && cyc < 20) begin
            exp_v = send_vec(32'hA1B2_C3D4, k);
            checks++;
            if (obs !== exp_v) begin
                errors++; $display("FAIL hold_byte%0d_cyc%0d: got %h expected %h", k, cyc, obs, exp_v);
            end
            byte_ready = (cyc % 2 == 0);
            if (byte_ready) k++;
            cyc++;
            @(negedge clock);
        end
        checks++;
        if (k != 4 || obs !== DONE_V) begin
            errors++; $display("FAIL hold_done: got %h bytes=%0d expected %h bytes=4", obs, k, DONE_V);
        end
        byte_ready = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_stall_abort();
        rd_data = 32'h5566_7788; start = 1'b1; byte_ready = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        byte_ready = 1'b0;
        for (int s = 1; s <= 4; s++) begin
            exp_v = send_vec(32'h5566_7788, 1);
            checks++;
            if (obs !== exp_v) begin
                errors++; $display("FAIL stall_hold%0d: got %h expected %h", s, obs, exp_v);
            end
            @(negedge clock);
        end
        checks++;
        if (obs !== ABORT_V) begin
            errors++; $display("FAIL stall_abort: got %h expected %h", obs, ABORT_V);
        end
        @(negedge clock);
        checks++;
        if (obs !== IDLE_V) begin
            errors++; $display("FAIL stall_idle_after_abort: got %h expected %h", obs, IDLE_V);
        end
        byte_ready = 1'b1;
    endtask

    task automatic test_stall_limit_ok();
        rd_data = 32'h0102_0304; start = 1'b1; byte_ready = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        byte_ready = 1'b0;
        repeat (3) @(negedge clock);
        byte_ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            exp_v = send_vec(32'h0102_0304, k);
            checks++;
            if (obs !== exp_v) begin
                errors++; $display("FAIL limit_byte%0d: got %h expected %h", k, obs, exp_v);
            end
            @(negedge clock);
        end
        checks++;
        if (obs !== DONE_V) begin
            errors++; $display("FAIL limit_done: got %h expected %h", obs, DONE_V);
        end
        @(negedge clock);
    endtask

    task automatic test_start_held();
        rd_data = 32'hA1B2_C3D4; start = 1'b1; byte_ready = 1'b1;
        @(negedge clock);
        rd_data = 32'h1122_3344;
        for (int k = 0; k < 4; k++) begin
            exp_v = send_vec(32'hA1B2_C3D4, k);
            checks++;
            if (obs !== exp_v) begin
                errors++; $display("FAIL held_first_byte%0d: got %h expected %h", k, obs, exp_v);
            end
            @(negedge clock);
        end
        checks++;
        if (obs !== DONE_V) begin
            errors++; $display("FAIL held_done: got %h expected %h", obs, DONE_V);
        end
        @(negedge clock);
        checks++;
        if (obs !== IDLE_V) begin
            errors++; $display("FAIL held_idle_gap: got %h expected %h", obs, IDLE_V);
        end
        @(negedge clock);
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            exp_v = send_vec(32'h1122_3344, k);
            checks++;
            if (obs !== exp_v) begin
                errors++; $display("FAIL held_second_byte%0d: got %h expected %h", k, obs, exp_v);
            end
            @(negedge clock);
        end
        @(negedge clock);
        @(negedge clock);
        checks++;
        if (obs !== IDLE_V) begin
            errors++; $display("FAIL held_no_queue: got %h expected %h", obs, IDLE_V);
        end
    endtask

    task automatic test_reset_mid();
        rd_data = 32'hDEAD_BEEF; start = 1'b1; byte_ready = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (2) @(negedge clock);
        #2 resetn = 1'b1;
        #1;
        checks++;
        if (obs !== IDLE_V) begin
            errors++; $display("FAIL midreset_async: got %h expected %h", obs, IDLE_V);
        end
        @(negedge clock);
        resetn = 1'b0;
        @(negedge clock);
        checks++;
        if (obs !== IDLE_V) begin
            errors++; $display("FAIL midreset_no_pulse: got %h expected %h", obs, IDLE_V);
        end
        rd_data = 32'hCAFE_F00D; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            exp_v = send_vec(32'hCAFE_F00D, k);
            checks++;
            if (obs !== exp_v) begin
                errors++; $display("FAIL midreset_byte%0d: got %h expected %h", k, obs, exp_v);
            end
            @(negedge clock);
        end
        checks++;
        if (obs !== DONE_V) begin
            errors++; $display("FAIL midreset_done: got %h expected %h", obs, DONE_V);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold_stable();
        test_stall_abort();
        test_stall_limit_ok();
        test_start_held();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
